// File: rtl/car_light_pkg.sv
// Shared constants for the indicator-lamp sequencer: state width and state codes.
package car_light_pkg;

    localparam int unsigned StateW = 3;

    localparam logic [StateW-1:0] StOff     = 3'd0;
    localparam logic [StateW-1:0] StIdle    = 3'd1;
    localparam logic [StateW-1:0] StLeft    = 3'd2;
    localparam logic [StateW-1:0] StRight   = 3'd3;
    localparam logic [StateW-1:0] StHazard  = 3'd4;
    localparam logic [StateW-1:0] StReverse = 3'd5;

endpackage

// File: rtl/blink_divider.sv
// Free-running divider producing the 50% duty led_clk plus a one-cycle strobe
// that is high in the first cycle led_clk reads 1.
module blink_divider #(
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic led_clk,
    output logic led_rise
);

    localparam int unsigned CntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);

    logic [CntW-1:0] div_cnt_q;
    logic            led_clk_q;
    logic            led_rise_q;
    logic            wrap;

    assign wrap = (div_cnt_q == CntMax);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q  <= '0;
            led_clk_q  <= 1'b0;
            led_rise_q <= 1'b0;
        end else begin
            led_rise_q <= 1'b0;
            if (wrap) begin
                div_cnt_q  <= '0;
                led_clk_q  <= ~led_clk_q;
                led_rise_q <= ~led_clk_q;
            end else begin
                div_cnt_q <= div_cnt_q + 1'b1;
            end
        end
    end

    assign led_clk  = led_clk_q;
    assign led_rise = led_rise_q;

endmodule

// File: rtl/car_light_ctrl.sv
// Indicator-lamp sequencer: prioritises power/hazard/reverse/turn requests and
// enforces a minimum blink count once a turn request is released.
module car_light_ctrl
    import car_light_pkg::*;
#(
    parameter int unsigned BLINK_DIV  = 25_000_000,
    parameter int unsigned MIN_BLINKS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power_on,
    input  logic              hazard,
    input  logic              reverse,
    input  logic              turn_left,
    input  logic              turn_right,
    output logic              led_clk,
    output logic              stay_left,
    output logic              stay_right,
    output logic              twinkle_left,
    output logic              twinkle_right,
    output logic [StateW-1:0] light_state
);

    localparam int unsigned BlinkW = $clog2(2 * MIN_BLINKS + 1);
    localparam logic [BlinkW-1:0] BlinkReload = BlinkW'(2 * MIN_BLINKS);

    logic              led_rise;
    logic [StateW-1:0] state_q, state_d;
    logic [BlinkW-1:0] blink_rem_q, blink_rem_d;
    logic              stay_left_q, stay_right_q, twinkle_left_q, twinkle_right_q;
    logic              stay_left_d, stay_right_d, twinkle_left_d, twinkle_right_d;

    blink_divider #(
        .BLINK_DIV(BLINK_DIV)
    ) u_divider (
        .clk     (clk),
        .rst     (rst),
        .led_clk (led_clk),
        .led_rise(led_rise)
    );

    // Exit test uses the pre-decrement count, so a final decrement to 0 exits one cycle later.
    always_comb begin
        state_d     = state_q;
        blink_rem_d = blink_rem_q;
        if (!power_on) begin
            state_d     = StOff;
            blink_rem_d = '0;
        end else if (hazard) begin
            state_d     = StHazard;
            blink_rem_d = '0;
        end else if (reverse) begin
            state_d     = StReverse;
            blink_rem_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (turn_left) begin
                        state_d     = StLeft;
                        blink_rem_d = BlinkReload;
                    end else if (turn_right) begin
                        state_d     = StRight;
                        blink_rem_d = BlinkReload;
                    end
                end
                StLeft: begin
                    if (turn_left) begin
                        blink_rem_d = BlinkReload;
                    end else if (turn_right) begin
                        state_d     = StRight;
                        blink_rem_d = BlinkReload;
                    end else if (blink_rem_q == '0) begin
                        state_d = StIdle;
                    end else if (led_rise) begin
                        blink_rem_d = blink_rem_q - 1'b1;
                    end
                end
                StRight: begin
                    if (turn_left) begin
                        state_d     = StLeft;
                        blink_rem_d = BlinkReload;
                    end else if (turn_right) begin
                        blink_rem_d = BlinkReload;
                    end else if (blink_rem_q == '0) begin
                        state_d = StIdle;
                    end else if (led_rise) begin
                        blink_rem_d = blink_rem_q - 1'b1;
                    end
                end
                default: begin
                    state_d     = StIdle;
                    blink_rem_d = '0;
                end
            endcase
        end
    end

    // Decode from the next state so lamp controls change on the same edge as the state.
    always_comb begin
        stay_left_d     = 1'b0;
        stay_right_d    = 1'b0;
        twinkle_left_d  = 1'b0;
        twinkle_right_d = 1'b0;
        case (state_d)
            StLeft:    twinkle_left_d = 1'b1;
            StRight:   twinkle_right_d = 1'b1;
            StHazard: begin
                twinkle_left_d  = 1'b1;
                twinkle_right_d = 1'b1;
            end
            StReverse: begin
                stay_left_d  = 1'b1;
                stay_right_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StOff;
            blink_rem_q     <= '0;
            stay_left_q     <= 1'b0;
            stay_right_q    <= 1'b0;
            twinkle_left_q  <= 1'b0;
            twinkle_right_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            blink_rem_q     <= blink_rem_d;
            stay_left_q     <= stay_left_d;
            stay_right_q    <= stay_right_d;
            twinkle_left_q  <= twinkle_left_d;
            twinkle_right_q <= twinkle_right_d;
        end
    end

    assign stay_left     = stay_left_q;
    assign stay_right    = stay_right_q;
    assign twinkle_left  = twinkle_left_q;
    assign twinkle_right = twinkle_right_q;
    assign light_state   = state_q;

endmodule

// File: tb/tb_car_light_ctrl.sv
// Directed bench for car_light_ctrl with BLINK_DIV=4, MIN_BLINKS=2.
module tb_car_light_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       power_on, hazard, reverse, turn_left, turn_right;
    logic       led_clk, stay_left, stay_right, twinkle_left, twinkle_right;
    logic [2:0] light_state;

    int checks = 0;
    int errors = 0;

    car_light_ctrl #(
        .BLINK_DIV (4),
        .MIN_BLINKS(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .power_on     (power_on),
        .hazard       (hazard),
        .reverse      (reverse),
        .turn_left    (turn_left),
        .turn_right   (turn_right),
        .led_clk      (led_clk),
        .stay_left    (stay_left),
        .stay_right   (stay_right),
        .twinkle_left (twinkle_left),
        .twinkle_right(twinkle_right),
        .light_state  (light_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lamp controls packed as {stay_l, stay_r, tw_l, tw_r}.
    function automatic logic [3:0] lamps();
        return {stay_left, stay_right, twinkle_left, twinkle_right};
    endfunction

    initial begin : stim
        int rises;
        int toggles;
        int n;
        logic prev;

        rst = 1'b1;
        power_on = 1'b1; hazard = 1'b0; reverse = 1'b0;
        turn_left = 1'b1; turn_right = 1'b0;
        step();
        step();
        check("reset_state", 32'(light_state), 32'd0);
        check("reset_lamps", 32'(lamps()), 32'h0);
        check("reset_ledclk", 32'(led_clk), 32'd0);
        check("reset_blink", 32'(dut.blink_rem_q), 32'd0);
        rst = 1'b0;

        // led_clk toggles at release+4, +8, +12...; OFF -> IDLE -> LEFT.
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("ledclk_k%0d", k), 32'(led_clk), 32'((k / 4) % 2));
            if (k == 1) check("idle_after_rel", 32'(light_state), 32'd1);
            else check($sformatf("left_k%0d", k), 32'(light_state), 32'd2);
        end
        check("left_lamps", 32'(lamps()), 32'b0010);
        check("left_hold_blink", 32'(dut.blink_rem_q), 32'd4);

        // LEFT -> RIGHT when only turn_right is high, then both high -> LEFT.
        turn_left = 1'b0; turn_right = 1'b1;
        step();
        check("l2r_state", 32'(light_state), 32'd3);
        check("l2r_blink", 32'(dut.blink_rem_q), 32'd4);
        check("l2r_lamps", 32'(lamps()), 32'b0001);
        turn_left = 1'b1;
        step();
        check("both_state", 32'(light_state), 32'd2);
        check("both_lamps", 32'(lamps()), 32'b0010);
        turn_right = 1'b0;

        // Hazard overrides LEFT; dropping it with no request returns to IDLE.
        hazard = 1'b1;
        step();
        check("haz_state", 32'(light_state), 32'd4);
        check("haz_lamps", 32'(lamps()), 32'b0011);
        check("haz_blink", 32'(dut.blink_rem_q), 32'd0);
        hazard = 1'b0; turn_left = 1'b0;
        step();
        check("haz_exit_state", 32'(light_state), 32'd1);
        check("haz_exit_lamps", 32'(lamps()), 32'h0);
        step();
        check("no_residual_left", 32'(light_state), 32'd1);

        // One-cycle turn_right pulse: RIGHT until 4 led_clk rises consumed.
        prev = led_clk;
        turn_right = 1'b1;
        step();
        check("pulse_right", 32'(light_state), 32'd3);
        turn_right = 1'b0;
        rises = (led_clk && !prev) ? 1 : 0;
        prev = led_clk;
        n = 0;
        while (rises < 4 && n < 60) begin
            step();
            n++;
            if (light_state !== 3'd3) check($sformatf("pulse_hold_n%0d", n), 32'(light_state), 32'd3);
            if (led_clk && !prev) rises++;
            prev = led_clk;
        end
        check("pulse_rises_bound", 32'(rises), 32'd4);
        step();
        check("pulse_last_right", 32'(light_state), 32'd3);
        check("pulse_blink_zero", 32'(dut.blink_rem_q), 32'd0);
        step();
        check("pulse_exit_state", 32'(light_state), 32'd1);
        check("pulse_exit_lamps", 32'(lamps()), 32'h0);

        // Hazard beats reverse; reverse takes over when hazard drops.
        reverse = 1'b1; hazard = 1'b1;
        step();
        check("hr_state", 32'(light_state), 32'd4);
        hazard = 1'b0;
        step();
        check("rev_state", 32'(light_state), 32'd5);
        check("rev_lamps", 32'(lamps()), 32'b1100);
        reverse = 1'b0;
        step();
        check("rev_exit", 32'(light_state), 32'd1);

        // Power drop forces OFF; divider keeps running.
        turn_left = 1'b1;
        step();
        check("pwr_pre_left", 32'(light_state), 32'd2);
        power_on = 1'b0;
        step();
        check("off_state", 32'(light_state), 32'd0);
        check("off_lamps", 32'(lamps()), 32'h0);
        toggles = 0;
        prev = led_clk;
        for (int k = 0; k < 10; k++) begin
            step();
            if (led_clk !== prev) toggles++;
            prev = led_clk;
        end
        check("off_ledclk_runs", 32'(toggles >= 2), 32'd1);
        check("off_still", 32'(light_state), 32'd0);

        // Asynchronous reset mid-RIGHT, applied between clock edges.
        power_on = 1'b1; turn_left = 1'b0;
        step();
        turn_right = 1'b1;
        step();
        check("pre_rst_right", 32'(light_state), 32'd3);
        turn_right = 1'b0;
        n = 0;
        while (led_clk !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("pre_rst_ledclk", 32'(led_clk), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_state", 32'(light_state), 32'd0);
        check("arst_lamps", 32'(lamps()), 32'h0);
        check("arst_ledclk", 32'(led_clk), 32'd0);
        check("arst_divcnt", 32'(dut.u_divider.div_cnt_q), 32'd0);
        check("arst_blink", 32'(dut.blink_rem_q), 32'd0);
        step();
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
